// File: rtl/lead_one_normalizer_pkg.sv
// Shared types and constants for the lead-one normalizer.
package lead_one_normalizer_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    // Width of a bit-position index for a w-bit word; at least one bit.
    function automatic int unsigned idx_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/lead_one_normalizer_if.sv
// Valid/ready input and output channels of the lead-one normalizer.
interface lead_one_normalizer_if
    import lead_one_normalizer_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
);
    localparam int unsigned IW = idx_w(W);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;
    logic          out_zero;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_zero
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_zero
    );

endinterface

// File: rtl/msb_encoder.sv
// Combinational most-significant-one encoder; yields 0 for an all-zero word.
module msb_encoder
    import lead_one_normalizer_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) (
    input  logic [W-1:0]        data,
    output logic [idx_w(W)-1:0] idx
);
    localparam int unsigned IW = idx_w(W);

    always_comb begin
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (data[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/lead_one_normalizer.sv
// Sequential lead-one normalizer: shifts one bit per cycle until the MSB is set,
// then holds the normalized word, its original leading-one index and a zero flag.
module lead_one_normalizer
    import lead_one_normalizer_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) (
    input logic                  clk,
    input logic                  rst_n,
    lead_one_normalizer_if.slave bus
);
    localparam int unsigned IW = idx_w(W);

    state_e        state;
    logic [W-1:0]  work;
    logic [IW-1:0] cnt;
    logic          work_zero;
    logic          msb_set;

    assign work_zero = (work == '0);
    assign msb_set   = work[W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            work          <= '0;
            cnt           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_idx   <= '0;
            bus.out_zero  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.in_valid) begin
                        work         <= bus.in_data;
                        cnt          <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= StShift;
                    end
                end
                StShift: begin
                    // A nonzero word never shifts to zero, so the zero test only
                    // fires for a word that arrived as zero.
                    if (msb_set || work_zero) begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= work;
                        bus.out_idx   <= work_zero ? '0 : (IW'(W - 1) - cnt);
                        bus.out_zero  <= work_zero;
                        state         <= StDone;
                    end else begin
                        work <= {work[W-2:0], 1'b0};
                        cnt  <= cnt + IW'(1);
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= StIdle;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lead_one_normalizer.sv
// Randomized self-checking bench for lead_one_normalizer with a latency-level model.
module tb_lead_one_normalizer;
    import lead_one_normalizer_pkg::*;

    localparam int MIdle = 0;
    localparam int MBusy = 1;
    localparam int MDone = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    lead_one_normalizer_if #(.W(8)) bus ();

    lead_one_normalizer #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference encoder on the word the model captured at acceptance.
    logic [7:0] m_word;
    logic [2:0] enc_idx;

    msb_encoder #(.W(8)) ref_enc (
        .data (m_word),
        .idx  (enc_idx)
    );

    always #5 clk = ~clk;

    // Leading-one position, or -1 for zero.
    function automatic int lead_pos(input logic [7:0] d);
        int p;
        p = -1;
        for (int i = 0; i < 8; i++) if (d[i]) p = i;
        return p;
    endfunction

    function automatic int lat_of(input logic [7:0] d);
        return (d == 8'h00) ? 1 : 8 - lead_pos(d);
    endfunction

    function automatic logic [7:0] norm_of(input logic [7:0] d);
        int unsigned v;
        if (d == 8'h00) return 8'h00;
        v = int'(d) * (1 << (7 - lead_pos(d)));
        return v[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: only tracks how many edges remain before the result must appear.
    int m_st;
    int m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st  <= MIdle;
            m_cnt <= 0;
        end else begin
            case (m_st)
                MIdle: if (bus.in_valid) begin
                    m_st   <= MBusy;
                    m_cnt  <= lat_of(bus.in_data) - 1;
                    m_word <= bus.in_data;
                end
                MBusy: if (m_cnt == 0) m_st <= MDone; else m_cnt <= m_cnt - 1;
                MDone: if (bus.out_ready) m_st <= MIdle;
                default: m_st <= MIdle;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready", 32'(bus.in_ready), 32'd1);
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_out_data", 32'(bus.out_data), 32'd0);
            check("rst_out_idx", 32'(bus.out_idx), 32'd0);
            check("rst_out_zero", 32'(bus.out_zero), 32'd0);
        end else begin
            check("in_ready", 32'(bus.in_ready), 32'(m_st == MIdle));
            check("out_valid", 32'(bus.out_valid), 32'(m_st == MDone));
            if (m_st == MDone) begin
                check("out_data", 32'(bus.out_data), 32'(norm_of(m_word)));
                check("out_zero", 32'(bus.out_zero), 32'(m_word == 8'h00));
                if (m_word == 8'h00) begin
                    check("out_idx_zero", 32'(bus.out_idx), 32'd0);
                end else begin
                    check("enc_vs_model", 32'(enc_idx), 32'(lead_pos(m_word)));
                    check("out_idx", 32'(bus.out_idx), 32'(enc_idx));
                end
            end
        end
    end

    // Present d once idle, scramble ignored inputs while busy, stall, then consume.
    task automatic send(input logic [7:0] d, input int stall);
        int n;
        n = 0;
        while (m_st != MIdle && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("timeout_idle", 32'd0, 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = 1'($urandom);
        @(negedge clk);
        n = 0;
        while (m_st != MDone && n < 20) begin
            bus.in_valid  = 1'($urandom);
            bus.in_data   = 8'($urandom);
            bus.out_ready = 1'($urandom);
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("timeout_done", 32'd0, 32'd1);
        for (int i = 0; i < stall; i++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'($urandom);
            bus.in_data   = 8'($urandom);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // Hand-computed pins on the model itself.
        check("pin_lat_80", 32'(lat_of(8'h80)), 32'd1);
        check("pin_lat_01", 32'(lat_of(8'h01)), 32'd8);
        check("pin_lat_16", 32'(lat_of(8'h16)), 32'd4);
        check("pin_lat_00", 32'(lat_of(8'h00)), 32'd1);
        check("pin_norm_16", 32'(norm_of(8'h16)), 32'hB0);
        check("pin_norm_05", 32'(norm_of(8'h05)), 32'hA0);
        check("pin_norm_01", 32'(norm_of(8'h01)), 32'h80);
        check("pin_pos_05", 32'(lead_pos(8'h05)), 32'd2);
        check("pin_pos_40", 32'(lead_pos(8'h40)), 32'd6);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(8'h80, 0);   // presented right at release
        send(8'h01, 0);
        send(8'h16, 1);
        send(8'h00, 0);
        send(8'h05, 5);

        // Abort an operation in its third SHIFT cycle.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_out_data", 32'(bus.out_data), 32'd0);
        check("abort_out_idx", 32'(bus.out_idx), 32'd0);
        check("abort_out_zero", 32'(bus.out_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send(8'h40, 0);

        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 3))
                0: d = 8'h00;
                1: d = 8'(1 << $urandom_range(0, 7));
                default: d = 8'($urandom);
            endcase
            send(d, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lead_one_normalizer.md
LEAD_ONE_NORMALIZER -- requirements
Module: lead_one_normalizer

Interface
REQ-001 Parameter: W, default 8, data width; the index width is log2(W), which is 3 at the default.
REQ-002 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  upstream word available.
REQ-005 in_ready  output  1  block can accept a word.
REQ-006 in_data  input  W  word to normalize; bit W-1 is the MSB.
REQ-007 out_valid  output  1  result available.
REQ-008 out_ready  input  1  downstream accepts the result.
REQ-009 out_data  output  W  normalized word, with its leading one in bit W-1.
REQ-010 out_idx  output  3  bit position of the leading one in the original word (7 for MSB, 0 for LSB).
REQ-011 out_zero  output  1  original word was all zeros.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-014 In IDLE, when in_valid=1 at a rising edge, the block SHALL do all of the following:
- load in_data into a working register;
- clear the shift counter to 0;
- go to SHIFT.
REQ-015 In SHIFT, each cycle SHALL act on the working register as follows:
- if bit W-1 is 1, or the register is all zeros, go to DONE with no shift;
- otherwise, shift the register left by 1 with zero fill, increment the counter, and stay in SHIFT.
REQ-016 On entry to DONE, the block SHALL set the outputs as follows:
- out_data = working register;
- out_idx = 7 - counter, or 0 if the word was zero;
- out_zero = 1 exactly when the word was zero.
REQ-017 For a nonzero input with its leading one at bit p, out_valid SHALL first be high 8-p rising edges after the accepting edge: 1 edge for p=7, 8 edges for p=0.
REQ-018 For a zero input, out_valid SHALL be high 1 edge after the accepting edge.
REQ-019 The shift counter SHALL never exceed 7; this holds by REQ-015.
REQ-020 In DONE, out_data, out_idx and out_zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 In DONE, when out_ready=1 at a rising edge, the block SHALL return to IDLE.
REQ-022 in_ready is 0 in DONE, so a new word SHALL NOT be accepted on the same edge that the result is consumed; the minimum spacing is one IDLE cycle.
REQ-023 in_data SHALL be sampled only on the accepting edge; changes to in_data during SHIFT or DONE SHALL have no effect.
REQ-024 out_idx for a nonzero word SHALL equal the 3-bit most-significant-one index of the original word: 7 for MSB down to 0 for LSB.
REQ-025 out_ready=1 outside DONE SHALL be ignored.

Reset
REQ-026 While rst_n=0, the state SHALL be IDLE and all of the following SHALL be 0:
- working register and counter;
- out_data, out_idx, out_zero, out_valid.
REQ-027 in_ready SHALL be 1 during and after reset.
REQ-028 Reset asserted mid-SHIFT or mid-DONE SHALL immediately abort the operation:
- the partial result is discarded;
- no out_valid pulse occurs after release.
REQ-029 The first accept after rst_n rises SHALL be possible on the first rising edge.

Structure
REQ-030 A shared package SHALL hold the state enum type (IDLE, SHIFT, DONE) and the default width constant of 8.
REQ-031 The block SHALL be a single module with no sub-module.
REQ-032 The verification bench SHALL instantiate the existing combinational MSB encoder as a reference model for out_idx.

Verification
REQ-033 Input 8'b1000_0000 -> out_valid 1 edge after accept; out_data=8'b1000_0000, out_idx=7, out_zero=0.
REQ-034 Input 8'b0000_0001 -> out_valid 8 edges after accept; out_data=8'b1000_0000, out_idx=0.
REQ-035 Input 8'b0001_0110 -> out_valid 4 edges after accept; out_data=8'b1011_0000, out_idx=4.
REQ-036 Input 8'h00 -> out_valid 1 edge after accept; out_zero=1, out_data=0, out_idx=0.
REQ-037 Input 8'h05, then out_ready held 0 for 5 cycles -> outputs stable with out_idx=2 and out_data=8'hA0; in_ready=0 throughout; return to IDLE on the edge where out_ready=1.
REQ-038 Input 8'h01, then rst_n pulsed low in the 3rd SHIFT cycle -> all outputs 0 immediately and in_ready=1; no out_valid after release; a following input 8'h40 yields out_idx=6.
